// File: rtl/usb_arb_pkg.sv
// Shared types and default widths for the USB frame arbiter.
// Widths fall back to the BLE capture defaults when constant.sv has not defined them.
`ifndef TAILLE_DATA_O
`define TAILLE_DATA_O 8
`endif
`ifndef TAILLE_CHANNEL
`define TAILLE_CHANNEL 6
`endif
`ifndef TAILLE_RSSI
`define TAILLE_RSSI 8
`endif

package usb_arb_pkg;
  localparam int NB_REQ_DEF = 4;
  localparam int DATA_W_DEF = `TAILLE_DATA_O;
  localparam int CHAN_W_DEF = `TAILLE_CHANNEL;
  localparam int RSSI_W_DEF = `TAILLE_RSSI;
  localparam int LEN_W_DEF  = 8;

  // The state names the word currently presented on data_o.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHAN = 3'd1,
    RSSI = 3'd2,
    LEN  = 3'd3,
    PAY  = 3'd4
  } arb_state_e;
endpackage

// File: rtl/usb_frame_arbiter_if.sv
// Bundle between the per-channel packet buffers, the arbiter and the USB output port.
interface usb_frame_arbiter_if
  import usb_arb_pkg::*;
#(
  parameter int NB_REQ = NB_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHAN_W = CHAN_W_DEF,
  parameter int RSSI_W = RSSI_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();
  // Handshakes: req_i[k] stays high until buffer k's last word is popped; rd_o[k] pops
  // rdata_i[k] at the clock edge it is high in; valid_o has no ready (USB never stalls).
  logic [NB_REQ-1:0]        req_i;
  logic [NB_REQ*CHAN_W-1:0] chan_i;
  logic [NB_REQ*RSSI_W-1:0] rssi_i;
  logic [NB_REQ*LEN_W-1:0]  len_i;
  logic [NB_REQ*DATA_W-1:0] rdata_i;
  logic [NB_REQ-1:0]        rd_o;
  logic [DATA_W-1:0]        data_o;
  logic                     valid_o;
  logic                     frame_o;
  logic [NB_REQ-1:0]        grant_o;
  logic                     busy_o;
  arb_state_e               state_dbg;

  modport master (
    input  req_i, chan_i, rssi_i, len_i, rdata_i,
    output rd_o, data_o, valid_o, frame_o, grant_o, busy_o, state_dbg
  );

  modport slave (
    output req_i, chan_i, rssi_i, len_i, rdata_i,
    input  rd_o, data_o, valid_o, frame_o, grant_o, busy_o, state_dbg
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning cyclically from ptr+1.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/usb_frame_arbiter.sv
// Streams one buffer's packet as a USB frame (chan, rssi, len, payload), granting buffers
// round-robin; all outputs registered except the rd_o pop strobe.
module usb_frame_arbiter
  import usb_arb_pkg::*;
#(
  parameter int NB_REQ = NB_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHAN_W = CHAN_W_DEF,
  parameter int RSSI_W = RSSI_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  usb_frame_arbiter_if.master bus
);
  localparam int IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [CHAN_W-1:0] chan_a  [NB_REQ];
  logic [RSSI_W-1:0] rssi_a  [NB_REQ];
  logic [LEN_W-1:0]  len_a   [NB_REQ];
  logic [DATA_W-1:0] rdata_a [NB_REQ];

  for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
    assign chan_a[g]  = bus.chan_i[g*CHAN_W +: CHAN_W];
    assign rssi_a[g]  = bus.rssi_i[g*RSSI_W +: RSSI_W];
    assign len_a[g]   = bus.len_i[g*LEN_W +: LEN_W];
    assign rdata_a[g] = bus.rdata_i[g*DATA_W +: DATA_W];
  end

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              active_q, active_d;
  logic [NB_REQ-1:0] grant_q, grant_d;
  logic [NB_REQ-1:0] win_gnt, rd;
  logic [IW-1:0]     win_idx;
  logic              pop;

  rr_arbiter #(.N(NB_REQ)) u_rr (
    .req (bus.req_i),
    .ptr (ptr_q),
    .en  (state_q == IDLE),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // A pop in LEN fetches payload word 1; PAY pops again while more than one word remains.
  assign pop = rst_i && (((state_q == LEN) && (len_q != '0)) ||
                         ((state_q == PAY) && (cnt_q > LEN_W'(1))));

  always_comb begin
    rd = '0;
    if (pop) rd[gidx_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    data_d   = '0;
    active_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_gnt != '0) begin
          state_d  = CHAN;
          ptr_d    = win_idx;
          gidx_d   = win_idx;
          grant_d  = win_gnt;
          len_d    = len_a[win_idx];
          data_d   = DATA_W'(chan_a[win_idx]);
          active_d = 1'b1;
        end
      end
      CHAN: begin
        state_d  = RSSI;
        data_d   = DATA_W'(rssi_a[gidx_q]);
        active_d = 1'b1;
      end
      RSSI: begin
        state_d  = LEN;
        data_d   = DATA_W'(len_q);
        active_d = 1'b1;
      end
      LEN: begin
        if (len_q == '0) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d  = PAY;
          cnt_d    = len_q;
          data_d   = rdata_a[gidx_q];
          active_d = 1'b1;
        end
      end
      PAY: begin
        if (cnt_q > LEN_W'(1)) begin
          cnt_d    = cnt_q - LEN_W'(1);
          data_d   = rdata_a[gidx_q];
          active_d = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(NB_REQ - 1);
      gidx_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      active_q <= 1'b0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      active_q <= active_d;
      grant_q  <= grant_d;
    end
  end

  assign bus.rd_o      = rd;
  assign bus.data_o    = data_q;
  assign bus.valid_o   = active_q;
  assign bus.frame_o   = active_q;
  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_usb_frame_arbiter.sv
// Bench for usb_frame_arbiter: directed vectors, round-robin/reset/max-length sequences and
// random traffic, all checked against a frame-level model of the packet buffers.
module tb_usb_frame_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 6;
  localparam int RW = 8;
  localparam int LW = 8;

  typedef struct {
    logic [N-1:0]  req;
    logic [CW-1:0] chan;
    logic [RW-1:0] rssi;
    logic [LW-1:0] len;
    logic [DW-1:0] pay0;
    int            exp_g;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  usb_frame_arbiter_if #(.NB_REQ(N), .DATA_W(DW), .CHAN_W(CW), .RSSI_W(RW), .LEN_W(LW)) bus ();

  usb_frame_arbiter #(.NB_REQ(N), .DATA_W(DW), .CHAN_W(CW), .RSSI_W(RW), .LEN_W(LW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Packet buffer contents as the bench loaded them.
  logic [CW-1:0] p_chan [N];
  logic [RW-1:0] p_rssi [N];
  logic [LW-1:0] p_len  [N];
  logic [DW-1:0] p_pay  [N][256];
  int            rd_idx [N];

  logic [DW-1:0] exp_q[$];
  int            win_log[$];
  int            mptr, cur_w, words_seen, frames_done, last_win, end_mode;
  bit            in_frame, prev_idle;
  logic [N-1:0]  pend_rd;
  vec_t          vecs [6];
  int            exp_rr [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++)
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      bus.chan_i[k*CW +: CW] = p_chan[k];
      bus.rssi_i[k*RW +: RW] = p_rssi[k];
      bus.len_i[k*LW +: LW]  = p_len[k];
      bus.rdata_i[k*DW +: DW] = (rd_idx[k] < int'(p_len[k])) ? p_pay[k][rd_idx[k]] : 8'hEE;
    end
  endtask

  task automatic load_pkt(input int k, input logic [CW-1:0] c, input logic [RW-1:0] r,
                          input logic [LW-1:0] l, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] v;
    v = base;
    p_chan[k] = c;
    p_rssi[k] = r;
    p_len[k]  = l;
    rd_idx[k] = 0;
    for (int i = 0; i < int'(l); i++) begin
      p_pay[k][i] = rnd ? DW'($urandom) : v;
      v = v + 8'h11;
    end
  endtask

  // One clock: sample outputs at the falling edge and advance the buffer/frame model.
  task automatic cycle();
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < N; k++)
        if (pend_rd[k]) begin
          if (rd_idx[k] >= int'(p_len[k])) flag_fail($sformatf("rd_underflow buf%0d", k));
          else rd_idx[k]++;
        end
    end
    if (!rst_n) begin
      chk("reset_out", {bus.valid_o, bus.frame_o, bus.busy_o, bus.grant_o, bus.data_o, bus.rd_o}, 0);
      mptr = N - 1;
      in_frame = 0;
      exp_q.delete();
      prev_idle = 1;
    end else begin
      if (prev_idle) begin
        chk("frame_start", bus.frame_o, (bus.req_i != 0));
        if (bus.frame_o && bus.req_i != 0) begin
          cur_w = rr_pick(mptr, bus.req_i);
          mptr = cur_w;
          chk("grant_start", bus.grant_o, 32'(1) << cur_w);
          exp_q.delete();
          exp_q.push_back(DW'(p_chan[cur_w]));
          exp_q.push_back(DW'(p_rssi[cur_w]));
          exp_q.push_back(DW'(p_len[cur_w]));
          for (int i = 0; i < int'(p_len[cur_w]); i++) exp_q.push_back(p_pay[cur_w][i]);
          in_frame = 1;
          words_seen = 0;
        end
      end
      if (bus.frame_o) chk("flags", {bus.valid_o, bus.busy_o}, 2'b11);
      if (in_frame && bus.frame_o) begin
        words_seen++;
        if (exp_q.size() == 0) flag_fail("frame_overrun");
        else chk("data", bus.data_o, exp_q.pop_front());
        chk("grant_hold", bus.grant_o, 32'(1) << cur_w);
        if (rd_idx[cur_w] < int'(p_len[cur_w]) && !bus.req_i[cur_w])
          flag_fail($sformatf("protocol req dropped by buf%0d", cur_w));
      end else if (in_frame) begin
        chk("frame_len", words_seen, 3 + int'(p_len[cur_w]));
        chk("pops", rd_idx[cur_w], p_len[cur_w]);
        in_frame = 0;
        frames_done++;
        last_win = cur_w;
        win_log.push_back(cur_w);
        case (end_mode)
          0: bus.req_i = '0;
          1: bus.req_i[cur_w] = 1'b0;
          default: load_pkt(cur_w, CW'($urandom), RW'($urandom), 1, 0, 1);
        endcase
      end
      if (!bus.frame_o)
        chk("idle_out", {bus.valid_o, bus.busy_o, bus.grant_o, bus.data_o, bus.rd_o}, 0);
      prev_idle = !bus.frame_o;
    end
    pend_rd = rst_n ? bus.rd_o : '0;
    drive_inputs();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    int cnt;
    target = frames_done + n;
    cnt = 0;
    while (frames_done < target && cnt < budget) begin
      cycle();
      cnt++;
    end
    if (frames_done < target) flag_fail("frame_timeout");
  endtask

  initial begin
    vecs[0] = '{4'b0100, 6'd37, 8'hC8, 8'd3, 8'hAA, 2};
    vecs[1] = '{4'b0001, 6'd0,  8'h5A, 8'd0, 8'h00, 0};
    vecs[2] = '{4'b0101, 6'd12, 8'h33, 8'd2, 8'h01, 2};
    vecs[3] = '{4'b1001, 6'd63, 8'hFF, 8'd1, 8'h7E, 3};
    vecs[4] = '{4'b1001, 6'd5,  8'h00, 8'd4, 8'h10, 0};
    vecs[5] = '{4'b1010, 6'd21, 8'h81, 8'd5, 8'h20, 1};
    exp_rr  = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    bus.req_i = '0;
    for (int k = 0; k < N; k++) load_pkt(k, '0, '0, '0, '0, 0);
    mptr = N - 1; prev_idle = 1; in_frame = 0; end_mode = 0; pend_rd = '0;
    frames_done = 0; last_win = -1; cur_w = 0; words_seen = 0;
    drive_inputs();

    // Reset held with every buffer requesting; first frame must come from buffer 0.
    for (int k = 0; k < N; k++) load_pkt(k, CW'(k + 1), RW'(8'h40 + k), 1, DW'(8'h10 * k), 0);
    bus.req_i = 4'b1111;
    drive_inputs();
    repeat (3) cycle();
    rst_n = 1'b1;
    wait_frames(1, 20);
    chk("reset_first_grant", last_win, 0);

    // Directed single-frame vectors.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++)
        if (vecs[i].req[k]) load_pkt(k, vecs[i].chan, vecs[i].rssi, vecs[i].len, vecs[i].pay0, 0);
      bus.req_i = vecs[i].req;
      drive_inputs();
      wait_frames(1, 300);
      chk($sformatf("vec%0d_grant", i), last_win, vecs[i].exp_g);
    end

    // Round-robin with all four continuously requesting, then only 0 and 3.
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    win_log.delete();
    end_mode = 2;
    for (int k = 0; k < N; k++) load_pkt(k, CW'(k), RW'(k), 1, 0, 1);
    bus.req_i = 4'b1111;
    drive_inputs();
    wait_frames(3, 100);
    bus.req_i = 4'b1001;
    wait_frames(1, 50);
    end_mode = 0;
    wait_frames(1, 50);
    chk("rr_count", win_log.size(), 5);
    for (int i = 0; i < 5 && i < win_log.size(); i++) chk("rr_order", win_log[i], exp_rr[i]);

    // Reset while payload word 2 of a len=10 frame is on data_o.
    load_pkt(2, 6'd17, 8'h99, 10, 8'h01, 0);
    bus.req_i = 4'b0100;
    drive_inputs();
    begin
      int guard;
      guard = 0;
      while (!(in_frame && words_seen == 5) && guard < 50) begin
        cycle();
        guard++;
      end
      if (!(in_frame && words_seen == 5)) flag_fail("midframe_timeout");
    end
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) load_pkt(k, CW'(k + 8), RW'(8'h60 + k), 2, 0, 1);
    bus.req_i = 4'b1111;
    drive_inputs();
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_frames(1, 50);
    chk("post_reset_grant", last_win, 0);

    // Maximum length frame on buffer 1.
    load_pkt(1, 6'd9, 8'h77, 8'd255, 0, 1);
    bus.req_i = 4'b0010;
    drive_inputs();
    wait_frames(1, 400);
    chk("maxlen_grant", last_win, 1);

    // Random traffic: buffers raise requests at random and drop them after being served.
    end_mode = 1;
    begin
      int base;
      int guard;
      base = frames_done;
      guard = 0;
      while (frames_done < base + 40 && guard < 3000) begin
        cycle();
        guard++;
        for (int k = 0; k < N; k++)
          if (!bus.req_i[k] && $urandom_range(0, 3) == 0) begin
            load_pkt(k, CW'($urandom), RW'($urandom), LW'($urandom_range(0, 6)), 0, 1);
            bus.req_i[k] = 1'b1;
          end
        drive_inputs();
      end
      if (frames_done < base + 40) flag_fail("random_timeout");
      guard = 0;
      while (bus.req_i != 0 && guard < 500) begin
        cycle();
        guard++;
      end
      if (bus.req_i != 0) flag_fail("drain_timeout");
    end
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
